// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake of lcd_bus_arbiter: two byte requesters with
// their pending bytes, message framing, and the arbiter's acks and grants.
interface lcd_bus_arbiter_if;
  logic       req0, req1;
  logic [7:0] byte0, byte1;
  logic       rs0, rs1;
  logic       last0, last1;
  logic       ack0, ack1;
  logic       grant0, grant1;

  modport master (
    output req0, req1, byte0, byte1, rs0, rs1, last0, last1,
    input  ack0, ack1, grant0, grant1
  );

  modport slave (
    input  req0, req1, byte0, byte1, rs0, rs1, last0, last1,
    output ack0, ack1, grant0, grant1
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Shares one 4-bit HD44780 bus between two byte requesters: runs power-up
// init, splits bytes into nibbles with lcd_en timing, and grants per message.
module lcd_bus_arbiter #(
  parameter int unsigned EN_HIGH   = 800,
  parameter int unsigned EN_LOW    = 800,
  parameter int unsigned LONG_WAIT = 60000,
  parameter int unsigned PWR_WAIT  = 600000
) (
  input  logic             clk,
  input  logic             rst_n,
  lcd_bus_arbiter_if.slave bus,
  output logic             lcd_rs,
  output logic             lcd_en,
  output logic [3:0]       lcd_data,
  output logic             init_done,
  output logic             busy
);

  localparam int unsigned MAX_EN   = (EN_HIGH > EN_LOW) ? EN_HIGH : EN_LOW;
  localparam int unsigned MAX_LONG = (PWR_WAIT > LONG_WAIT) ? PWR_WAIT : LONG_WAIT;
  localparam int unsigned MAX_WAIT = (MAX_EN > MAX_LONG) ? MAX_EN : MAX_LONG;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(EN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(EN_LOW - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_WAIT - 1);
  localparam logic [3:0]       INIT_LEN  = 4'd12;

  typedef enum logic [2:0] {
    S_PWR,
    S_INIT,
    S_IDLE,
    S_EN,
    S_GAP,
    S_LONG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       init_idx;   // next init item to issue
  logic             init_long;  // issued init item is followed by LONG
  logic [3:0]       low_nib;
  logic             second;     // low nibble of the current byte is on the bus
  logic             slow;
  logic             lock;
  logic             owner;
  logic             last_owner;

  // Init list as nibbles: 3,3,3,2 then bytes 28, 0C, 06, 01; {long_after, nibble}.
  logic [4:0] init_item;
  always_comb begin
    init_item = 5'h00;
    case (init_idx)
      4'd0, 4'd1, 4'd2: init_item = {1'b1, 4'h3};
      4'd3:             init_item = {1'b0, 4'h2};
      4'd4:             init_item = {1'b0, 4'h2};
      4'd5:             init_item = {1'b0, 4'h8};
      4'd6:             init_item = {1'b0, 4'h0};
      4'd7:             init_item = {1'b0, 4'hC};
      4'd8:             init_item = {1'b0, 4'h0};
      4'd9:             init_item = {1'b0, 4'h6};
      4'd10:            init_item = {1'b0, 4'h0};
      4'd11:            init_item = {1'b1, 4'h1};
      default:          init_item = 5'h00;
    endcase
  end

  // An abandoned lock (owner dropped req) falls through to plain arbitration.
  logic       pick_valid;
  logic       pick;
  logic [7:0] pick_byte;
  logic       pick_rs;
  logic       pick_last;
  always_comb begin
    pick_valid = 1'b0;
    pick       = 1'b0;
    if (lock && (owner ? bus.req1 : bus.req0)) begin
      pick_valid = 1'b1;
      pick       = owner;
    end else if (bus.req0 && bus.req1) begin
      pick_valid = 1'b1;
      pick       = ~last_owner;
    end else if (bus.req0 || bus.req1) begin
      pick_valid = 1'b1;
      pick       = bus.req1;
    end
    pick_byte = pick ? bus.byte1 : bus.byte0;
    pick_rs   = pick ? bus.rs1   : bus.rs0;
    pick_last = pick ? bus.last1 : bus.last0;
  end

  // NOTE: reset is sampled synchronously here, so every register (including
  // the counter and FSM state) must be listed in this branch explicitly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_PWR;
      cnt        <= '0;
      init_idx   <= '0;
      init_long  <= 1'b0;
      low_nib    <= '0;
      second     <= 1'b0;
      slow       <= 1'b0;
      lock       <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b1;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.grant0 <= 1'b0;
      bus.grant1 <= 1'b0;
    end else begin
      // NOTE: defaults assigned first make the acks one-cycle pulses; later
      // non-blocking assignments in the same block override them.
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;

      case (state)
        S_PWR: begin
          if (cnt == PWR_LAST) begin
            cnt   <= '0;
            state <= S_INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_INIT: begin
          lcd_en    <= 1'b1;
          lcd_rs    <= 1'b0;
          lcd_data  <= init_item[3:0];
          init_long <= init_item[4];
          init_idx  <= init_idx + 4'd1;
          cnt       <= '0;
          state     <= S_EN;
        end

        S_IDLE: begin
          if (pick_valid) begin
            lcd_en     <= 1'b1;
            lcd_rs     <= pick_rs;
            lcd_data   <= pick_byte[7:4];
            low_nib    <= pick_byte[3:0];
            slow       <= !pick_rs && (pick_byte == 8'h01 || pick_byte == 8'h02);
            second     <= 1'b0;
            bus.ack0   <= !pick;
            bus.ack1   <= pick;
            bus.grant0 <= !pick;
            bus.grant1 <= pick;
            owner      <= pick;
            last_owner <= pick;
            lock       <= !pick_last;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= S_EN;
          end else begin
            bus.grant0 <= 1'b0;
            bus.grant1 <= 1'b0;
            lock       <= 1'b0;
          end
        end

        S_EN: begin
          if (cnt == HIGH_LAST) begin
            lcd_en <= 1'b0;
            cnt    <= '0;
            state  <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == LOW_LAST) begin
            cnt <= '0;
            if (!init_done) begin
              if (init_long) begin
                state <= S_LONG;
              end else begin
                lcd_en    <= 1'b1;
                lcd_data  <= init_item[3:0];
                init_long <= init_item[4];
                init_idx  <= init_idx + 4'd1;
                state     <= S_EN;
              end
            end else if (!second) begin
              lcd_en   <= 1'b1;
              lcd_data <= low_nib;
              second   <= 1'b1;
              state    <= S_EN;
            end else if (slow) begin
              state <= S_LONG;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
              if (!lock) begin
                bus.grant0 <= 1'b0;
                bus.grant1 <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LONG: begin
          if (cnt == LONG_LAST) begin
            cnt <= '0;
            if (!init_done) begin
              if (init_idx == INIT_LEN) begin
                init_done <= 1'b1;
                busy      <= 1'b0;
                state     <= S_IDLE;
              end else begin
                lcd_en    <= 1'b1;
                lcd_data  <= init_item[3:0];
                init_long <= init_item[4];
                init_idx  <= init_idx + 4'd1;
                state     <= S_EN;
              end
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
              if (!lock) begin
                bus.grant0 <= 1'b0;
                bus.grant1 <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: expected {rs, nibble} pairs are queued as
// requests are driven and popped on every lcd_en rise.
module tb_lcd_bus_arbiter;
  localparam int EN_HIGH   = 4;
  localparam int EN_LOW    = 4;
  localparam int LONG_WAIT = 20;
  localparam int PWR_WAIT  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_rs, lcd_en, init_done, busy;
  logic [3:0] lcd_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [4:0] sb[$];

  lcd_bus_arbiter_if bus();

  lcd_bus_arbiter #(
    .EN_HIGH  (EN_HIGH),
    .EN_LOW   (EN_LOW),
    .LONG_WAIT(LONG_WAIT),
    .PWR_WAIT (PWR_WAIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data),
    .init_done(init_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bus monitor: nibble order, pulse widths, hold stability, grant sanity.
  logic       m_prev_en = 1'b0;
  int         m_hi = 0;
  int         m_lo = 100;
  logic [4:0] m_cur = 5'h00;
  logic [4:0] m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev_en = 1'b0;
      m_hi = 0;
      m_lo = 100;
    end else begin
      if (lcd_en && !m_prev_en) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL nibble: unexpected lcd_en rise got rs=%b data=%h", lcd_rs, lcd_data);
        end else begin
          m_exp = sb.pop_front();
          if ({lcd_rs, lcd_data} !== m_exp) begin
            miscompares++;
            $display("FAIL nibble: got rs=%b data=%h want rs=%b data=%h",
                     lcd_rs, lcd_data, m_exp[4], m_exp[3:0]);
          end
        end
        vectors++;
        if (m_lo < EN_LOW) begin
          miscompares++;
          $display("FAIL en_low: low for %0d cycles want >= %0d", m_lo, EN_LOW);
        end
        m_cur = {lcd_rs, lcd_data};
        m_hi = 1;
      end else if (lcd_en) begin
        m_hi++;
        if ({lcd_rs, lcd_data} !== m_cur) begin
          miscompares++;
          $display("FAIL hold_high: got %h want %h", {lcd_rs, lcd_data}, m_cur);
        end
      end else if (m_prev_en) begin
        vectors++;
        if (m_hi != EN_HIGH) begin
          miscompares++;
          $display("FAIL en_high: high for %0d cycles want %0d", m_hi, EN_HIGH);
        end
        m_lo = 1;
        if ({lcd_rs, lcd_data} !== m_cur) begin
          miscompares++;
          $display("FAIL hold_gap: got %h want %h", {lcd_rs, lcd_data}, m_cur);
        end
      end else begin
        m_lo++;
        if (m_lo <= EN_LOW && {lcd_rs, lcd_data} !== m_cur) begin
          miscompares++;
          $display("FAIL hold_gap: got %h want %h", {lcd_rs, lcd_data}, m_cur);
        end
      end
      if (bus.grant0 && bus.grant1) begin
        miscompares++;
        $display("FAIL grant_onehot: grant0=%b grant1=%b want at most one", bus.grant0, bus.grant1);
      end
      if ((bus.ack0 && !bus.grant0) || (bus.ack1 && !bus.grant1)) begin
        miscompares++;
        $display("FAIL ack_grant: ack=%b%b grant=%b%b want ack only to owner",
                 bus.ack1, bus.ack0, bus.grant1, bus.grant0);
      end
      m_prev_en = lcd_en;
    end
  end

  task automatic push_byte(input logic rs, input logic [7:0] b);
    sb.push_back({rs, b[7:4]});
    sb.push_back({rs, b[3:0]});
  endtask

  task automatic push_init();
    logic [3:0] nibs [12];
    nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    for (int i = 0; i < 12; i++) sb.push_back({1'b0, nibs[i]});
  endtask

  task automatic wait_ack(output int who, output int at);
    int n = 0;
    who = -1;
    at = 0;
    while (n < 300 && who < 0) begin
      @(negedge clk);
      n++;
      if (bus.ack0 || bus.ack1) begin
        who = bus.ack1 ? 1 : 0;
        at = cyc;
      end
    end
    vectors++;
    if (who < 0) begin
      miscompares++;
      $display("FAIL ack_timeout: no ack within %0d cycles", n);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n < 300 && busy !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  // Release reset at this negedge and follow the full init sequence.
  task automatic replay_init(input int remain);
    int n = 0;
    int first_rise = -1;
    int acks = 0;
    rst_n = 1'b1;
    while (n < 400 && init_done !== 1'b1) begin
      @(negedge clk);
      n++;
      if (lcd_en === 1'b1 && first_rise < 0) first_rise = n - 1;
      if (bus.ack0 || bus.ack1) acks++;
    end
    vectors++;
    if (n - 1 != 186) begin
      miscompares++;
      $display("FAIL init_latency: init_done after %0d cycles want 186", n - 1);
    end
    vectors++;
    if (first_rise != PWR_WAIT) begin
      miscompares++;
      $display("FAIL pwr_wait: first en rise at %0d want %0d", first_rise, PWR_WAIT);
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL init_ack: %0d acks during init want 0", acks);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL init_busy: busy=%b at init_done want 0", busy);
    end
    vectors++;
    if (sb.size() != remain) begin
      miscompares++;
      $display("FAIL init_nibbles: %0d entries pending want %0d", sb.size(), remain);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({lcd_en, lcd_rs, lcd_data, init_done, busy,
         bus.grant0, bus.grant1, bus.ack0, bus.ack1} !== 11'b0_0_0000_0_1_0000) begin
      miscompares++;
      $display("FAIL reset_state: en=%b rs=%b data=%h done=%b busy=%b grant=%b%b ack=%b%b",
               lcd_en, lcd_rs, lcd_data, init_done, busy,
               bus.grant1, bus.grant0, bus.ack1, bus.ack0);
    end
    push_init();
    replay_init(0);
  endtask

  task automatic test_fairness();
    int w0, w1, w2, t0, t1, t2;
    push_byte(1'b1, 8'hA5);
    push_byte(1'b1, 8'h5A);
    push_byte(1'b1, 8'h3C);
    bus.byte0 = 8'hA5; bus.rs0 = 1'b1; bus.last0 = 1'b1; bus.req0 = 1'b1;
    bus.byte1 = 8'h5A; bus.rs1 = 1'b1; bus.last1 = 1'b1; bus.req1 = 1'b1;
    wait_ack(w0, t0);
    vectors++;
    if (w0 != 0 || lcd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL fair_first: ack from %0d en=%b want requester 0 en=1", w0, lcd_en);
    end
    bus.byte0 = 8'h3C;
    wait_ack(w1, t1);
    vectors++;
    if (w1 != 1 || t1 - t0 != 17) begin
      miscompares++;
      $display("FAIL fair_second: ack from %0d after %0d want requester 1 after 17", w1, t1 - t0);
    end
    bus.req1 = 1'b0;
    wait_ack(w2, t2);
    vectors++;
    if (w2 != 0 || t2 - t1 != 17) begin
      miscompares++;
      $display("FAIL fair_third: ack from %0d after %0d want requester 0 after 17", w2, t2 - t1);
    end
    bus.req0 = 1'b0;
    wait_idle(w0);
  endtask

  task automatic test_single();
    int w, t, n;
    push_byte(1'b1, 8'h41);
    bus.byte0 = 8'h41; bus.rs0 = 1'b1; bus.last0 = 1'b1; bus.req0 = 1'b1;
    wait_ack(w, t);
    vectors++;
    if (w != 0 || bus.grant0 !== 1'b1 || lcd_data !== 4'h4 || lcd_rs !== 1'b1) begin
      miscompares++;
      $display("FAIL single_accept: ack=%0d grant0=%b data=%h rs=%b want 0 1 4 1",
               w, bus.grant0, lcd_data, lcd_rs);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.ack0 !== 1'b0 || bus.grant0 !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pulse: ack0=%b grant0=%b want 0 1", bus.ack0, bus.grant0);
    end
    wait_idle(n);
    vectors++;
    if (n + 1 != 16 || bus.grant0 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: idle after %0d grant0=%b want 16 0", n + 1, bus.grant0);
    end
  endtask

  task automatic test_multi_byte();
    int w, t, tp, n;
    push_byte(1'b1, 8'h12);
    push_byte(1'b1, 8'h34);
    push_byte(1'b1, 8'h56);
    push_byte(1'b1, 8'h9A);
    bus.byte0 = 8'h12; bus.rs0 = 1'b1; bus.last0 = 1'b0; bus.req0 = 1'b1;
    wait_ack(w, tp);
    bus.byte0 = 8'h34;
    bus.byte1 = 8'h9A; bus.rs1 = 1'b1; bus.last1 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_ack(w, t);
      vectors++;
      if (w != 0 || bus.grant1 !== 1'b0 || t - tp != 17) begin
        miscompares++;
        $display("FAIL multi_lock: byte %0d ack from %0d grant1=%b gap %0d want 0 0 17",
                 i + 2, w, bus.grant1, t - tp);
      end
      tp = t;
      bus.byte0 = 8'h56;
      bus.last0 = 1'b1;
    end
    bus.req0 = 1'b0;
    wait_ack(w, t);
    vectors++;
    if (w != 1 || t - tp != 17) begin
      miscompares++;
      $display("FAIL multi_handover: ack from %0d gap %0d want 1 17", w, t - tp);
    end
    bus.req1 = 1'b0;
    wait_idle(n);
  endtask

  task automatic test_slow_cmd();
    int w, t0, t1, t2, n;
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h80);
    push_byte(1'b1, 8'h41);
    bus.byte0 = 8'h01; bus.rs0 = 1'b0; bus.last0 = 1'b0; bus.req0 = 1'b1;
    wait_ack(w, t0);
    bus.byte0 = 8'h80;
    wait_ack(w, t1);
    vectors++;
    if (t1 - t0 != 37) begin
      miscompares++;
      $display("FAIL slow_clear: gap after 0x01 is %0d want 37", t1 - t0);
    end
    bus.byte0 = 8'h41; bus.rs0 = 1'b1; bus.last0 = 1'b1;
    wait_ack(w, t2);
    vectors++;
    if (t2 - t1 != 17) begin
      miscompares++;
      $display("FAIL fast_cmd: gap after 0x80 is %0d want 17", t2 - t1);
    end
    bus.req0 = 1'b0;
    wait_idle(n);
  endtask

  task automatic test_reset_mid();
    int w, t, n;
    push_byte(1'b1, 8'h7E);
    bus.byte0 = 8'h7E; bus.rs0 = 1'b1; bus.last0 = 1'b1; bus.req0 = 1'b1;
    wait_ack(w, t);
    @(negedge clk);
    rst_n = 1'b0;
    bus.byte0 = 8'h41;
    @(negedge clk);
    vectors++;
    if ({lcd_en, bus.grant0, bus.grant1, init_done, busy} !== 5'b0_0_0_0_1) begin
      miscompares++;
      $display("FAIL reset_mid: en=%b grant=%b%b done=%b busy=%b want 0 00 0 1",
               lcd_en, bus.grant1, bus.grant0, init_done, busy);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    push_init();
    push_byte(1'b1, 8'h41);
    replay_init(2);
    wait_ack(w, t);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL reset_resume: ack from %0d want 0", w);
    end
    bus.req0 = 1'b0;
    wait_idle(n);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d nibbles never appeared want 0", sb.size());
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.byte0 = 8'h00; bus.byte1 = 8'h00;
    bus.rs0 = 1'b0; bus.rs1 = 1'b0;
    bus.last0 = 1'b0; bus.last1 = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_multi_byte();
    test_slow_cmd();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
